// File: rtl/rlight_tlul_periph.sv
`default_nettype none
// ============================================================================
// Module   : tlul_pkg / rlight_tlul_periph
// Purpose  : TL-UL device that drives 8 LEDs with a rotating pattern.
//            REGA (0x0) holds the 8-bit pattern. REGB (0x4) holds enable
//            (bit0), direction (bit1, 1=right) and the step prescaler
//            reload value P (bits 31:8). While enabled, the pattern rotates
//            once every P+1 cycles.
// Ports    : clk_i  - system clock, rising edge
//            rst_i  - synchronous active-high reset
//            tl_i   - TL-UL A channel request plus d_ready
//            tl_o   - TL-UL D channel response plus a_ready
//            led_o  - LED drive, equal to the current pattern
// Revision : 1.0 - initial release
// ============================================================================

package tlul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  localparam logic [15:0] D_USER_DEFAULT  = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module rlight_tlul_periph #(
  parameter int PRESC_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic [7:0]        led_o
);

  import tlul_pkg::*;

  localparam logic [11:0] ADDR_REGA = 12'h000;
  localparam logic [11:0] ADDR_REGB = 12'h004;

  // Register state
  logic [7:0]         pattern_q, pattern_d;
  logic [31:0]        regb_q, regb_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Registered response
  logic               rsp_valid_q, rsp_valid_d;
  logic [2:0]         rsp_opcode_q, rsp_opcode_d;
  logic [1:0]         rsp_size_q, rsp_size_d;
  logic [7:0]         rsp_source_q, rsp_source_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_error_q, rsp_error_d;

  // Request decode
  logic [11:0]        addr;
  logic               hit_a, hit_b;
  logic               is_get, is_put;
  logic               req_err;
  logic               a_ready;
  logic               accept;
  logic               wr_a, wr_b;
  logic [31:0]        rdata;
  logic [31:0]        regb_wr;

  // Stepping
  logic               enable;
  logic               dir_right;
  logic [PRESC_W-1:0] reload;
  logic               step;

  always_comb begin
    addr    = tl_i.a_address[11:0];
    hit_a   = (addr == ADDR_REGA);
    hit_b   = (addr == ADDR_REGB);
    is_get  = (tl_i.a_opcode == GET);
    is_put  = (tl_i.a_opcode == PUT_FULL_DATA) || (tl_i.a_opcode == PUT_PARTIAL_DATA);
    req_err = !(is_get || is_put) || !(hit_a || hit_b);

    // A new request may enter when the response slot is free or drains now.
    a_ready = !rsp_valid_q || tl_i.d_ready;
    accept  = tl_i.a_valid && a_ready;

    // Only byte 0 of REGA is backed by storage.
    wr_a    = accept && is_put && hit_a && tl_i.a_mask[0];
    wr_b    = accept && is_put && hit_b;

    rdata = 32'h0;
    if (hit_a) begin
      rdata = {24'h0, pattern_q};
    end else if (hit_b) begin
      rdata = regb_q;
    end

    regb_wr = regb_q;
    for (int b = 0; b < 4; b++) begin
      if (tl_i.a_mask[b]) begin
        regb_wr[8*b +: 8] = tl_i.a_data[8*b +: 8];
      end
    end
    regb_wr[7:2] = 6'h00;  // reserved bits are not stored
  end

  always_comb begin
    enable    = regb_q[0];
    dir_right = regb_q[1];
    reload    = regb_q[8 +: PRESC_W];
    step      = enable && (cnt_q == '0);

    regb_d    = regb_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;

    if (wr_b) begin
      regb_d = regb_wr;
      cnt_d  = regb_wr[8 +: PRESC_W];
    end else if (!enable || step) begin
      cnt_d  = reload;
    end else begin
      cnt_d  = cnt_q - PRESC_W'(1);
    end

    // A host write to the pattern overrides a step landing on the same edge.
    if (wr_a) begin
      pattern_d = tl_i.a_data[7:0];
    end else if (step) begin
      pattern_d = dir_right ? {pattern_q[0], pattern_q[7:1]}
                            : {pattern_q[6:0], pattern_q[7]};
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_size_d   = rsp_size_q;
    rsp_source_d = rsp_source_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;

    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_opcode_d = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      rsp_size_d   = tl_i.a_size;
      rsp_source_d = tl_i.a_source;
      rsp_data_d   = (is_get && !req_err) ? rdata : 32'h0;
      rsp_error_d  = req_err;
    end else if (tl_i.d_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pattern_q    <= 8'h01;
      regb_q       <= 32'h0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= ACCESS_ACK;
      rsp_size_q   <= 2'h0;
      rsp_source_q <= 8'h00;
      rsp_data_q   <= 32'h0;
      rsp_error_q  <= 1'b0;
    end else begin
      pattern_q    <= pattern_d;
      regb_q       <= regb_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_size_q   <= rsp_size_d;
      rsp_source_q <= rsp_source_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid_q;
    tl_o.d_opcode = rsp_opcode_q;
    tl_o.d_param  = 3'h0;
    tl_o.d_size   = rsp_size_q;
    tl_o.d_source = rsp_source_q;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = rsp_data_q;
    tl_o.d_user   = D_USER_DEFAULT;
    tl_o.d_error  = rsp_error_q;
    tl_o.a_ready  = a_ready;
  end

  assign led_o = pattern_q;

  // Request fields that carry no meaning for this device.
  logic unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:12], tl_i.a_user};

endmodule

`default_nettype wire

// File: tb/tb_rlight_tlul_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_rlight_tlul_periph
// Purpose  : Directed self-checking bench for rlight_tlul_periph.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rlight_tlul_periph;

  import tlul_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic [7:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  rlight_tlul_periph #(.PRESC_W(24)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tl_i  (tl_i),
    .tl_o  (tl_o),
    .led_o (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction with d_ready high; returns at the first
  // falling edge where the response is visible.
  task automatic xact(input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask,
                      input logic [7:0] src,
                      output logic [31:0] rdata, output logic err,
                      output logic [2:0] dop);
    int t;
    @(negedge clk);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_data    = data;
    tl_i.a_mask    = mask;
    tl_i.a_source  = src;
    tl_i.a_size    = 2'd2;
    tl_i.d_ready   = 1'b1;
    t = 0;
    while (!tl_o.a_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!tl_o.a_ready) chk("a_ready_wait", 32'(tl_o.a_ready), 32'd1);
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tl_o.d_valid && t < 20);
    if (!tl_o.d_valid) chk("d_valid_wait", 32'(tl_o.d_valid), 32'd1);
    chk("d_source", 32'(tl_o.d_source), 32'(src));
    rdata = tl_o.d_data;
    err   = tl_o.d_error;
    dop   = tl_o.d_opcode;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [2:0]  op;

  initial begin
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);

    xact(GET, 32'h0, 32'h0, 4'hF, 8'h11, rd, er, op);
    chk("get_a_rst", rd, 32'h00000001);
    chk("get_a_rst_err", 32'(er), 32'd0);
    chk("get_a_rst_op", 32'(op), 32'(ACCESS_ACK_DATA));

    // Pattern write, only byte 0 used
    xact(PUT_FULL_DATA, 32'h0, 32'h12345678, 4'hF, 8'h12, rd, er, op);
    chk("put_a_op", 32'(op), 32'(ACCESS_ACK));
    chk("put_a_data", rd, 32'h0);
    chk("put_a_err", 32'(er), 32'd0);
    xact(GET, 32'h0, 32'h0, 4'hF, 8'h13, rd, er, op);
    chk("get_a_78", rd, 32'h00000078);
    chk("led_78", 32'(led), 32'h78);
    xact(PUT_PARTIAL_DATA, 32'h0, 32'h000000AB, 4'hE, 8'h14, rd, er, op);
    chk("led_mask0_off", 32'(led), 32'h78);

    // Control register: big prescaler, no step within 10 cycles
    xact(PUT_FULL_DATA, 32'h4, 32'hFFFFFF01, 4'hF, 8'h15, rd, er, op);
    xact(GET, 32'h4, 32'h0, 4'hF, 8'h16, rd, er, op);
    chk("get_b_ff01", rd, 32'hFFFFFF01);
    repeat (10) @(negedge clk);
    chk("led_no_step", 32'(led), 32'h78);
    xact(PUT_FULL_DATA, 32'h4, 32'hFFFFFFFD, 4'hF, 8'h17, rd, er, op);
    xact(GET, 32'h4, 32'h0, 4'hF, 8'h18, rd, er, op);
    chk("get_b_rsvd", rd, 32'hFFFFFF01);
    xact(PUT_PARTIAL_DATA, 32'h4, 32'h00000000, 4'h1, 8'h19, rd, er, op);
    xact(GET, 32'h4, 32'h0, 4'hF, 8'h1A, rd, er, op);
    chk("get_b_byte0", rd, 32'hFFFFFF00);

    // Error responses, no side effects (enable is 0 here)
    xact(GET, 32'h8, 32'h0, 4'hF, 8'h20, rd, er, op);
    chk("get_8_err", 32'(er), 32'd1);
    chk("get_8_data", rd, 32'h0);
    xact(PUT_FULL_DATA, 32'h8, 32'hFFFFFFFF, 4'hF, 8'h21, rd, er, op);
    chk("put_8_err", 32'(er), 32'd1);
    xact(3'h2, 32'h0, 32'h000000FF, 4'hF, 8'h22, rd, er, op);
    chk("badop_err", 32'(er), 32'd1);
    chk("badop_op", 32'(op), 32'(ACCESS_ACK));
    chk("badop_led", 32'(led), 32'h78);
    xact(GET, 32'h4, 32'h0, 4'hF, 8'h23, rd, er, op);
    chk("get_b_after_err", rd, 32'hFFFFFF00);

    // Back-pressure: d_ready low for 3 cycles
    @(negedge clk);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = GET; tl_i.a_address = 32'h0;
    tl_i.a_source = 8'h05; tl_i.d_ready = 1'b0;
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("stall_d_data", tl_o.d_data, 32'h00000078);
      chk("stall_a_ready", 32'(tl_o.a_ready), 32'd0);
    end
    tl_i.d_ready = 1'b1;
    #1 chk("stall_release_a_ready", 32'(tl_o.a_ready), 32'd1);
    @(negedge clk);
    chk("stall_drained", 32'(tl_o.d_valid), 32'd0);

    // Back-to-back requests
    @(negedge clk);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = GET; tl_i.a_address = 32'h0;
    tl_i.a_source = 8'h01; tl_i.a_size = 2'd2;
    @(posedge clk);
    #1 tl_i.a_address = 32'h4; tl_i.a_source = 8'h02; tl_i.a_size = 2'd1;
    @(negedge clk);
    chk("b2b_src1", 32'(tl_o.d_source), 32'h01);
    chk("b2b_data1", tl_o.d_data, 32'h00000078);
    chk("b2b_a_ready", 32'(tl_o.a_ready), 32'd1);
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    @(negedge clk);
    chk("b2b_src2", 32'(tl_o.d_source), 32'h02);
    chk("b2b_size2", 32'(tl_o.d_size), 32'd1);
    chk("b2b_data2", tl_o.d_data, 32'hFFFFFF00);
    @(negedge clk);
    chk("b2b_drained", 32'(tl_o.d_valid), 32'd0);

    // P=2, left: step 3 cycles after the control write
    xact(PUT_FULL_DATA, 32'h0, 32'h00000081, 4'hF, 8'h30, rd, er, op);
    xact(PUT_FULL_DATA, 32'h4, 32'h00000201, 4'hF, 8'h31, rd, er, op);
    chk("p2_t0", 32'(led), 32'h81);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("p2_t%0d", i), 32'(led), (i < 3) ? 32'h81 : (i < 6) ? 32'h03 : 32'h06);
    end

    // P=0, right: step every cycle
    xact(PUT_FULL_DATA, 32'h4, 32'h00000000, 4'hF, 8'h32, rd, er, op);
    xact(PUT_FULL_DATA, 32'h0, 32'h00000001, 4'hF, 8'h33, rd, er, op);
    xact(PUT_FULL_DATA, 32'h4, 32'h00000003, 4'hF, 8'h34, rd, er, op);
    chk("p0_t0", 32'(led), 32'h01);
    @(negedge clk);
    chk("p0_t1", 32'(led), 32'h80);
    @(negedge clk);
    chk("p0_t2", 32'(led), 32'h40);

    // Write and step on the same edge: write wins
    xact(PUT_FULL_DATA, 32'h0, 32'h00000011, 4'hF, 8'h35, rd, er, op);
    chk("wr_wins_t0", 32'(led), 32'h11);
    @(negedge clk);
    chk("wr_wins_t1", 32'(led), 32'h88);

    // Reset with a response pending and stepping enabled
    @(negedge clk);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = GET; tl_i.a_address = 32'h0;
    tl_i.a_source = 8'h40; tl_i.d_ready = 1'b0;
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_d_valid", 32'(tl_o.d_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("mid_rst_led", 32'(led), 32'h01);
    tl_i.d_ready = 1'b1;
    xact(GET, 32'h4, 32'h0, 4'hF, 8'h41, rd, er, op);
    chk("mid_rst_regb", rd, 32'h00000000);
    repeat (3) @(negedge clk);
    chk("mid_rst_led_hold", 32'(led), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
